// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the multi-channel byte-serial memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    TAIL = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam logic [1:0] IO_SEL = 2'b11;
  localparam int IO_HI = 17;
  localparam int IO_LO = 16;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // Byte counts at or above the port width collapse to the widest access.
  function automatic logic [1:0] clamp_len(input logic [1:0] len, input int maxb);
    return (int'(len) >= maxb) ? 2'(maxb - 1) : len;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request channels plus the byte-wide RAM/IO bus of the memory port arbiter.
interface mem_port_arbiter_if #(
  parameter int NCH = 2
);
  logic              rdy;
  logic [NCH-1:0]    req;
  logic [NCH-1:0]    wr;
  logic [NCH*32-1:0] addr;
  logic [NCH*2-1:0]  len;
  logic [NCH*32-1:0] wdata;
  logic [NCH-1:0]    flush;
  logic [NCH-1:0]    gnt;
  logic [NCH-1:0]    done;
  logic [31:0]       rdata;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [31:0]       mem_a;
  logic              mem_wr;

  modport master (
    output rdy, req, wr, addr, len, wdata, flush, mem_din,
    input  gnt, done, rdata, mem_dout, mem_a, mem_wr
  );

  modport slave (
    input  rdy, req, wr, addr, len, wdata, flush, mem_din,
    output gnt, done, rdata, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// One-hot channel selector: round-robin from a rotating start pointer, or fixed lowest-index priority.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int ARB_MODE = ARB_RR
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] i_req,
  input  logic           i_en,
  output logic [NCH-1:0] o_gnt
);
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_nxt;
  logic [PW-1:0] w_idx;
  logic [PW:0]   w_sum;
  logic          w_found;
  logic          w_hit;

  // Scan channels starting at the pointer, wrapping modulo NCH; first requester wins.
  always_comb begin
    o_gnt     = '0;
    w_ptr_nxt = r_ptr;
    w_found   = 1'b0;
    w_sum     = '0;
    w_idx     = '0;
    w_hit     = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      w_sum     = ((ARB_MODE == ARB_FIXED) ? '0 : {1'b0, r_ptr}) + (PW+1)'(i);
      w_sum     = (w_sum >= (PW+1)'(NCH)) ? (w_sum - (PW+1)'(NCH)) : w_sum;
      w_idx     = w_sum[PW-1:0];
      w_hit     = i_en && !w_found && i_req[w_idx];
      o_gnt     = o_gnt | (w_hit ? (NCH'(1) << w_idx) : '0);
      w_ptr_nxt = w_hit ? ((w_idx == PW'(NCH - 1)) ? '0 : (w_idx + PW'(1))) : w_ptr_nxt;
      w_found   = w_found | w_hit;
    end
  end

  // Pointer moves only when a grant is issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_nxt;
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates NCH request channels onto the byte-wide RAM/IO bus, serialising 1..MAXB byte accesses.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int MAXB     = 4,
  parameter int ARB_MODE = ARB_RR
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  state_e         r_state, w_state_nxt;
  logic [PW-1:0]  r_ch, w_win_idx;
  logic [NCH-1:0] w_win, w_ch_onehot;
  logic [31:0]    r_addr, r_wdata, r_data;
  logic [31:0]    w_sel_addr, w_sel_wdata, w_addr_k, w_wshift;
  logic [1:0]     r_len, r_k, w_sel_len, w_km1;
  logic           r_wr, w_sel_wr, w_io, w_abort, w_last, w_arb_en;

  assign w_arb_en = bus.rdy && (r_state == IDLE);

  rr_arbiter #(.NCH(NCH), .ARB_MODE(ARB_MODE)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .i_req (bus.req),
    .i_en  (w_arb_en),
    .o_gnt (w_win)
  );

  // Select the winning channel's request fields.
  always_comb begin
    w_win_idx   = '0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_len   = '0;
    w_sel_wr    = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      w_win_idx   = w_win[i] ? PW'(i) : w_win_idx;
      w_sel_addr  = w_win[i] ? bus.addr[i*32 +: 32] : w_sel_addr;
      w_sel_wdata = w_win[i] ? bus.wdata[i*32 +: 32] : w_sel_wdata;
      w_sel_len   = w_win[i] ? clamp_len(bus.len[i*2 +: 2], MAXB) : w_sel_len;
      w_sel_wr    = w_win[i] ? bus.wr[i] : w_sel_wr;
    end
  end

  assign w_io        = (r_addr[IO_HI:IO_LO] == IO_SEL);
  assign w_last      = (r_k == r_len);
  assign w_km1       = r_k - 2'd1;
  assign w_addr_k    = r_addr + {30'd0, r_k};
  assign w_wshift    = r_wdata >> {r_k, 3'b000};
  assign w_ch_onehot = NCH'(1) << r_ch;
  // Only non-IO reads may be cancelled; IO reads have side effects once started.
  assign w_abort     = (r_state inside {RD, TAIL, DONE}) && !r_wr && !w_io && bus.flush[r_ch];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; rdy low freezes the sequence.
  always_comb begin
    w_state_nxt = r_state;
    if (!bus.rdy) begin
      w_state_nxt = r_state;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = (|w_win) ? (w_sel_wr ? WR : RD) : IDLE;
        RD:      w_state_nxt = w_abort ? IDLE : (w_last ? TAIL : RD);
        TAIL:    w_state_nxt = w_abort ? IDLE : DONE;
        WR:      w_state_nxt = w_last ? DONE : WR;
        DONE:    w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Request latch, byte counter and read-byte assembly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ch    <= '0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_data  <= 32'd0;
      r_len   <= 2'd0;
      r_k     <= 2'd0;
      r_wr    <= 1'b0;
    end else if (bus.rdy) begin
      case (r_state)
        IDLE: begin
          if (|w_win) begin
            r_ch    <= w_win_idx;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_len   <= w_sel_len;
            r_wr    <= w_sel_wr;
            r_k     <= 2'd0;
            r_data  <= 32'd0;
          end
        end
        RD: begin
          if (r_k != 2'd0) begin
            r_data <= r_data | ({24'd0, bus.mem_din} << {w_km1, 3'b000});
          end
          if (!w_last) begin
            r_k <= r_k + 2'd1;
          end
        end
        TAIL: r_data <= r_data | ({24'd0, bus.mem_din} << {r_len, 3'b000});
        WR: begin
          if (!w_last) begin
            r_k <= r_k + 2'd1;
          end
        end
        default: r_k <= r_k;
      endcase
    end
  end

  // Bus and handshake outputs decoded from the current state.
  always_comb begin
    bus.gnt      = '0;
    bus.done     = '0;
    bus.rdata    = 32'd0;
    bus.mem_a    = 32'd0;
    bus.mem_dout = 8'd0;
    bus.mem_wr   = 1'b0;
    case (r_state)
      RD, TAIL: begin
        bus.gnt   = w_ch_onehot;
        bus.mem_a = w_addr_k;
      end
      WR: begin
        bus.gnt      = w_ch_onehot;
        bus.mem_a    = w_addr_k;
        bus.mem_dout = w_wshift[7:0];
        bus.mem_wr   = bus.rdy;
      end
      DONE: begin
        bus.gnt   = w_ch_onehot;
        bus.done  = (bus.rdy && !w_abort) ? w_ch_onehot : '0;
        bus.rdata = (bus.rdy && !w_abort && !r_wr) ? r_data : 32'd0;
      end
      default: bus.gnt = '0;
    endcase
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: NCH=2 round-robin port with a RAM model, plus NCH=3 fixed and round-robin ports.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [2:0] exp_rr [4];

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NCH(2)) bus_a ();
  mem_port_arbiter_if #(.NCH(3)) bus_b ();
  mem_port_arbiter_if #(.NCH(3)) bus_c ();

  mem_port_arbiter #(.NCH(2), .MAXB(4), .ARB_MODE(0)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  mem_port_arbiter #(.NCH(3), .MAXB(4), .ARB_MODE(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  mem_port_arbiter #(.NCH(3), .MAXB(4), .ARB_MODE(0)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    case (a)
      32'h100: return 8'h11;
      32'h101: return 8'h22;
      32'h102: return 8'h33;
      32'h103: return 8'h44;
      32'h200: return 8'h55;
      32'h201: return 8'h66;
      32'h202: return 8'h77;
      32'h203: return 8'h88;
      default: return a[7:0] ^ 8'hA5;
    endcase
  endfunction

  // RAM answers one cycle after the address and stalls with the rest of the system.
  always @(posedge clk) begin
    if (bus_a.rdy) bus_a.mem_din <= ram_byte(bus_a.mem_a);
  end

  assign bus_b.mem_din = 8'h00;
  assign bus_c.mem_din = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    exp_rr[0] = 3'b001; exp_rr[1] = 3'b010; exp_rr[2] = 3'b100; exp_rr[3] = 3'b001;
    bus_a.rdy = 1'b1; bus_a.req = '0; bus_a.wr = '0; bus_a.addr = '0;
    bus_a.len = '0; bus_a.wdata = '0; bus_a.flush = '0;
    bus_b.rdy = 1'b1; bus_b.req = '0; bus_b.wr = '0; bus_b.addr = '0;
    bus_b.len = '0; bus_b.wdata = '0; bus_b.flush = '0;
    bus_c.rdy = 1'b1; bus_c.req = '0; bus_c.wr = '0; bus_c.addr = '0;
    bus_c.len = '0; bus_c.wdata = '0; bus_c.flush = '0;

    repeat (2) tick();
    chk("rst_gnt", 32'(bus_a.gnt), 32'd0);
    chk("rst_done", 32'(bus_a.done), 32'd0);
    chk("rst_rdata", bus_a.rdata, 32'd0);
    chk("rst_mem_a", bus_a.mem_a, 32'd0);
    chk("rst_dout", 32'(bus_a.mem_dout), 32'd0);
    chk("rst_mem_wr", 32'(bus_a.mem_wr), 32'd0);
    rst = 1'b1;
    tick();

    // Both channels read 4 bytes; ch0 first, ch1 follows after the idle gap.
    bus_a.addr = {32'h200, 32'h100};
    bus_a.len  = 4'b1111;
    bus_a.req  = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rd0_addr", bus_a.mem_a, 32'h100 + 32'(k));
      chk("rd0_gnt", 32'(bus_a.gnt), 32'h1);
    end
    tick();
    chk("rd0_tail_addr", bus_a.mem_a, 32'h103);
    chk("rd0_tail_done", 32'(bus_a.done), 32'd0);
    tick();
    chk("rd0_done", 32'(bus_a.done), 32'h1);
    chk("rd0_rdata", bus_a.rdata, 32'h44332211);
    bus_a.req = 2'b10;
    tick();
    chk("gap_mem_a", bus_a.mem_a, 32'd0);
    chk("gap_gnt", 32'(bus_a.gnt), 32'd0);
    tick();
    chk("rd1_addr0", bus_a.mem_a, 32'h200);
    chk("rd1_gnt", 32'(bus_a.gnt), 32'h2);
    repeat (5) tick();
    chk("rd1_done", 32'(bus_a.done), 32'h2);
    chk("rd1_rdata", bus_a.rdata, 32'h88776655);
    bus_a.req = 2'b00;
    tick();

    // Two-byte write on ch1.
    bus_a.addr[63:32]  = 32'h40;
    bus_a.len[3:2]     = 2'b01;
    bus_a.wdata[63:32] = 32'h0000BEEF;
    bus_a.wr           = 2'b10;
    bus_a.req          = 2'b10;
    tick();
    chk("wr_a0", bus_a.mem_a, 32'h40);
    chk("wr_d0", 32'(bus_a.mem_dout), 32'hEF);
    chk("wr_we0", 32'(bus_a.mem_wr), 32'h1);
    chk("wr_gnt", 32'(bus_a.gnt), 32'h2);
    tick();
    chk("wr_a1", bus_a.mem_a, 32'h41);
    chk("wr_d1", 32'(bus_a.mem_dout), 32'hBE);
    chk("wr_we1", 32'(bus_a.mem_wr), 32'h1);
    tick();
    chk("wr_done", 32'(bus_a.done), 32'h2);
    chk("wr_done_we", 32'(bus_a.mem_wr), 32'd0);
    bus_a.req = 2'b00;
    bus_a.wr  = 2'b00;
    tick();

    // Flush at k=1 of a non-IO read aborts it.
    bus_a.addr[31:0] = 32'h1000;
    bus_a.len[1:0]   = 2'b11;
    bus_a.req        = 2'b01;
    tick();
    chk("fl_addr0", bus_a.mem_a, 32'h1000);
    tick();
    chk("fl_addr1", bus_a.mem_a, 32'h1001);
    bus_a.flush = 2'b01;
    tick();
    chk("fl_abort_mem_a", bus_a.mem_a, 32'd0);
    chk("fl_abort_gnt", 32'(bus_a.gnt), 32'd0);
    bus_a.req   = 2'b00;
    bus_a.flush = 2'b00;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("fl_no_done", 32'(bus_a.done), 32'd0);
    end

    // Same flush on an IO-region read is ignored.
    bus_a.addr[31:0] = 32'h30000;
    bus_a.req        = 2'b01;
    tick();
    chk("io_addr0", bus_a.mem_a, 32'h30000);
    tick();
    bus_a.flush = 2'b01;
    tick();
    chk("io_addr2", bus_a.mem_a, 32'h30002);
    chk("io_gnt", 32'(bus_a.gnt), 32'h1);
    repeat (3) tick();
    chk("io_done", 32'(bus_a.done), 32'h1);
    chk("io_rdata", bus_a.rdata, 32'hA6A7A4A5);
    bus_a.req   = 2'b00;
    bus_a.flush = 2'b00;
    tick();

    // Single-byte read flushed in its DONE cycle: no pulse.
    bus_a.addr[31:0] = 32'h100;
    bus_a.len[1:0]   = 2'b00;
    bus_a.req        = 2'b01;
    tick();
    chk("l0_addr", bus_a.mem_a, 32'h100);
    repeat (2) tick();
    bus_a.flush = 2'b01;
    #1;
    chk("dfl_done", 32'(bus_a.done), 32'd0);
    chk("dfl_rdata", bus_a.rdata, 32'd0);
    bus_a.req   = 2'b00;
    bus_a.flush = 2'b00;
    tick();
    chk("dfl_idle_gnt", 32'(bus_a.gnt), 32'd0);

    // rdy low for three cycles in the middle of a ch1 read.
    bus_a.len[3:2] = 2'b11;
    bus_a.addr[63:32] = 32'h200;
    bus_a.req = 2'b10;
    tick();
    chk("st_addr0", bus_a.mem_a, 32'h200);
    tick();
    chk("st_addr1", bus_a.mem_a, 32'h201);
    bus_a.rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("st_hold_addr", bus_a.mem_a, 32'h201);
      chk("st_hold_we", 32'(bus_a.mem_wr), 32'd0);
      chk("st_hold_done", 32'(bus_a.done), 32'd0);
    end
    bus_a.rdy = 1'b1;
    tick();
    chk("st_addr2", bus_a.mem_a, 32'h202);
    repeat (2) tick();
    chk("st_tail_done", 32'(bus_a.done), 32'd0);
    tick();
    chk("st_done", 32'(bus_a.done), 32'h2);
    chk("st_rdata", bus_a.rdata, 32'h88776655);
    bus_a.req = 2'b00;
    tick();

    // Write crossing the 32-bit wrap, with a one-cycle stall on the first byte.
    bus_a.addr[31:0]  = 32'hFFFFFFFF;
    bus_a.len[1:0]    = 2'b01;
    bus_a.wdata[31:0] = 32'h0000A55A;
    bus_a.wr          = 2'b01;
    bus_a.req         = 2'b01;
    tick();
    chk("wrap_d0", 32'(bus_a.mem_dout), 32'h5A);
    chk("wrap_we0", 32'(bus_a.mem_wr), 32'h1);
    bus_a.rdy = 1'b0;
    #1;
    chk("wrap_stall_we", 32'(bus_a.mem_wr), 32'd0);
    chk("wrap_stall_addr", bus_a.mem_a, 32'hFFFFFFFF);
    tick();
    bus_a.rdy = 1'b1;
    #1;
    chk("wrap_resume_we", 32'(bus_a.mem_wr), 32'h1);
    chk("wrap_resume_addr", bus_a.mem_a, 32'hFFFFFFFF);
    tick();
    chk("wrap_addr1", bus_a.mem_a, 32'h0);
    chk("wrap_d1", 32'(bus_a.mem_dout), 32'hA5);
    tick();
    chk("wrap_done", 32'(bus_a.done), 32'h1);
    bus_a.req = 2'b00;
    bus_a.wr  = 2'b00;
    tick();

    // Asynchronous reset in the middle of a write.
    bus_a.addr[31:0]  = 32'h50;
    bus_a.len[1:0]    = 2'b11;
    bus_a.wdata[31:0] = 32'h44332211;
    bus_a.wr          = 2'b01;
    bus_a.req         = 2'b01;
    tick();
    tick();
    chk("ar_addr1", bus_a.mem_a, 32'h51);
    rst       = 1'b0;
    bus_a.req = 2'b00;
    bus_a.wr  = 2'b00;
    #1;
    chk("ar_we", 32'(bus_a.mem_wr), 32'd0);
    chk("ar_mem_a", bus_a.mem_a, 32'd0);
    chk("ar_gnt", 32'(bus_a.gnt), 32'd0);
    chk("ar_dout", 32'(bus_a.mem_dout), 32'd0);
    tick();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("ar_no_done", 32'(bus_a.done), 32'd0);
      chk("ar_idle_a", bus_a.mem_a, 32'd0);
    end

    // All three channels requesting continuously: fixed priority vs round-robin.
    bus_b.req = 3'b111;
    bus_c.req = 3'b111;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("fix_gnt", 32'(bus_b.gnt), 32'h1);
      chk("rr_gnt", 32'(bus_c.gnt), 32'(exp_rr[j]));
      repeat (2) tick();
      chk("rr_done", 32'(bus_c.done), 32'(exp_rr[j]));
      tick();
    end
    bus_b.req = 3'b000;
    bus_c.req = 3'b000;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Parametrised successor to the two-client memory controller. Arbitrates NCH request channels onto the single byte-wide RAM/IO bus and serialises 1–MAXB-byte reads and writes into per-byte bus cycles, with round-robin or fixed-priority selection, per-channel flush, and IO-safe abort rules. Sits between the instruction cache / MEM stage (and future prefetch or DMA channels) and the `mem_din`/`mem_dout`/`mem_a`/`mem_wr` pins of `cpu`.

## Interface
- NCH, 2, number of request channels; channel 0 has highest fixed priority.
- MAXB, 4, maximum bytes per access, from 1 to 4.
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- rdy  in  1  global ready; low freezes the block.
- req  in  NCH  per-channel request level.
- wr  in  NCH  per-channel direction: 1 = write.
- addr  in  NCH*32  per-channel byte address.
- len  in  NCH*2  per-channel byte count minus 1; values at or above MAXB are clamped to MAXB-1.
- wdata  in  NCH*32  per-channel write data, little-endian.
- flush  in  NCH  per-channel cancel.
- gnt  out  NCH  one-hot; marks the channel currently being served.
- done  out  NCH  one-cycle completion pulse.
- rdata  out  32  read result, shared by all channels; valid only while a done bit is high.
- mem_din  in  8  RAM read byte.
- mem_dout  out  8  RAM write byte.
- mem_a  out  32  RAM address.
- mem_wr  out  1  1 = write.

## Operation
- States:
  - IDLE: arbitrate. On a winner c, latch c, addr, len, wr and wdata, set gnt[c], then go to RD or WR.
  - RD: issue addr+k for k = 0..len, one address per cycle. From k ≥ 1, capture mem_din as byte k-1. After issuing k = len, go to TAIL.
  - TAIL: capture byte len. mem_a holds the last address; mem_wr = 0. Go to DONE.
  - WR: drive mem_a = addr+k, mem_dout = wdata byte k, mem_wr = 1, for k = 0..len. Then go to DONE.
  - DONE: pulse done[c]. For reads, drive rdata = assembled bytes, zero-extended above byte len. Clear gnt. Go to IDLE.
- Arbitration:
  - Round-robin: search starts at the index after the last granted channel, wrapping modulo NCH. The pointer updates only on a grant.
  - Fixed priority: the lowest requesting index wins.
- Requesters hold req and all fields stable until done or flush. The block samples the fields only in IDLE.
- IO region is addr[17:16] == 2'b11.
- Flush rules:
  - flush[c] while c is granted, in RD/TAIL/DONE, on a non-IO read: abort. Next state is IDLE, done is suppressed, gnt clears.
  - Writes and IO reads are never aborted; they run to DONE and pulse done normally.
  - flush on a non-granted channel has no effect.
- rdy low: state, counters, captured bytes and the arbitration pointer all hold. mem_wr is forced to 0 and mem_a holds. No capture and no done pulse occur. The block resumes exactly where it stopped.
- Address arithmetic is 32-bit and wraps modulo 2^32; crossing 0x2FFFF→0x30000 is not special-cased.

## Timing
- Reset values:
  - state IDLE, round-robin pointer 0.
  - gnt, done and rdata all 0.
  - mem_a, mem_dout and mem_wr all 0.
- With req seen in IDLE at cycle t:
  - Read: addresses on mem_a at t+1 … t+1+len. done and rdata at t+3+len, i.e. latency len+3.
  - Write: bytes at t+1 … t+1+len. done at t+2+len.
- Minimum gap between accesses: DONE is followed by one IDLE cycle before the next first address.
- Outside RD/WR/TAIL: mem_wr = 0, mem_dout = 0, mem_a = 0.
- Flush sampled in cycle n takes effect in cycle n+1: mem_a returns to 0 and the block is in IDLE.
- Flush in the same cycle as DONE on a non-IO read suppresses that done pulse.

## Structure
- Shared package `mem_arb_pkg`:
  - state enum (IDLE, RD, TAIL, WR, DONE);
  - IO_SEL = 2'b11 and its bit positions [17:16];
  - ARB_RR/ARB_FIXED mode constants;
  - len encoding helper.
- One sub-module `rr_arbiter` (NCH, ARB_MODE): request vector and enable in, one-hot grant out, internal pointer.

## Test plan
- NCH=2 round-robin, both channels requesting 4-byte reads at 0x100 and 0x200 with RAM bytes 11 22 33 44 → ch0 done at t+6 with rdata 0x44332211. Ch1 is granted next, its first address appears two cycles after ch0's done, and it completes with its own data.
- 2-byte write ch1, addr 0x40, wdata 0xBEEF → mem_wr high for 2 cycles with (0x40, EF) then (0x41, BE); done[1] at t+3.
- flush[0] at k=1 of a 4-byte read at 0x1000 → IDLE next cycle, no done. Same flush on a read at 0x30000 → access completes and done[0] pulses.
- rdy low for 3 cycles mid-read → mem_wr=0 and mem_a held while low; rdata still correct; done delayed by exactly 3 cycles.
- ARB_MODE=1, NCH=3, all channels requesting continuously → ch0 served every access. With round-robin → grant order 0, 1, 2, 0.
- rst asserted during WR k=1 → all outputs 0 immediately (asynchronous); after release, state is IDLE and no done pulse occurs.
